spike_window_classifier: RTL and testbench
==========================================

# spike_window_classifier

Readout stage downstream of the spiking network's output layer. It takes the 10 output-neuron spike lines, counts spikes per class over a fixed inference window started by a request pulse, then scans the counts sequentially to find the winning class. It reports the winner index, the winning count and a tie flag with a one-cycle valid pulse. It replaces free-running per-class counters with a windowed, self-clearing classification result suitable for driving `uo_out`.

## Interface
Parameters:
- `NUM_CLASSES`, 10: number of spike inputs / classes.
- `WIDTH_P`, 8: per-class counter width; counters saturate at 2^WIDTH_P-1.
- `WINDOW`, 64: number of cycles in which spikes are sampled; legal range is 1 to 65535.
- `CLASS_W`, 4: width of the class index; 2^CLASS_W must be at least NUM_CLASSES.

Ports:
- `clk_i`, in, 1: single clock; all state updates on its rising edge.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `start_i`, in, 1: begin-window request; honoured only in IDLE.
- `spike_i`, in, NUM_CLASSES: one spike bit per class, sampled every ACCUM cycle.
- `class_o`, out, CLASS_W: winning class index.
- `max_count_o`, out, WIDTH_P: spike count of the winning class.
- `tie_o`, out, 1: at least one other class equals the winning count.
- `valid_o`, out, 1: one-cycle pulse when the three result outputs above update.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: go to ACCUM when `start_i`=1. Otherwise stay.
  - ACCUM: stay for exactly WINDOW cycles, then go to SCAN.
  - SCAN: stay for exactly NUM_CLASSES cycles, then go to DONE.
  - DONE: stay for one cycle, then go to IDLE.
- Entering ACCUM:
  - All class counters clear to 0.
  - The window counter loads to 0.
- Each ACCUM cycle:
  - For every i, `count[i]` increments by 1 if `spike_i[i]`=1.
  - Counts saturate at 2^WIDTH_P-1 and never wrap.
- SCAN walks index k from 0 to NUM_CLASSES-1, one index per cycle, using a running best index, best count and tie flag.
  - k=0: best index=0, best count=count[0], tie=0.
  - count[k] > best count: best index=k, best count=count[k], tie=0.
  - count[k] = best count (k>0): tie=1; best index is unchanged, so the lowest index wins a tie.
  - count[k] < best count: no change.
- Entering DONE:
  - `class_o`, `max_count_o` and `tie_o` register the running best values.
  - `valid_o`=1 for that single DONE cycle.
- Result outputs hold their value until the next DONE. They are not cleared by a new `start_i`.
- All-zero window: `class_o`=0, `max_count_o`=0, `tie_o`=1 (because NUM_CLASSES>1).
- `start_i` in ACCUM, SCAN or DONE is ignored and not queued.
- `spike_i` is ignored outside ACCUM. This includes the cycle in which `start_i` is accepted.
- Reset (`rst_ni`=0 at a rising edge), from any state:
  - State goes to IDLE.
  - All counters and the scan registers clear to 0.
  - `class_o`, `max_count_o`, `tie_o`, `valid_o` and `busy_o` all go to 0.
  - A window interrupted by reset produces no result.

## Timing
- Let E0 be the edge that samples `start_i`=1 in IDLE.
  - `busy_o` rises after E0.
  - `spike_i` is sampled at edges E1 to E_WINDOW.
  - SCAN runs at edges E_WINDOW+1 to E_WINDOW+NUM_CLASSES.
- `valid_o` is high in the cycle between edges E_(WINDOW+NUM_CLASSES) and E_(WINDOW+NUM_CLASSES+1). With defaults, that is E74 to E75.
- `busy_o` falls after E_(WINDOW+NUM_CLASSES+1).
  - The earliest next accepted `start_i` is at that same edge plus one.
  - Request-to-request period is WINDOW+NUM_CLASSES+2 cycles.
- All outputs are registered. No combinational path exists from any input to any output.
- Internal window counter width is enough to hold WINDOW, i.e. up to 16 bits.

## Test plan
- **Single winner:** defaults; `start_i` pulse; `spike_i[3]`=1 every ACCUM cycle and `spike_i[7]`=1 on alternate cycles.
  - Expect `class_o`=3, `max_count_o`=64, `tie_o`=0.
  - Expect `valid_o` high for exactly 1 cycle, 74 edges after E0.
- **Tie:** `spike_i[2]` and `spike_i[8]` both held at 1 for the whole window.
  - Expect `class_o`=2, `max_count_o`=64, `tie_o`=1.
- **Silent window:** `spike_i`=0 throughout.
  - Expect `class_o`=0, `max_count_o`=0, `tie_o`=1.
- **Saturation:** WINDOW=300; `spike_i[5]` held at 1, `spike_i[1]` high for 200 cycles.
  - Expect `class_o`=5, `max_count_o`=255, `tie_o`=0.
- **Start while busy, then back-to-back:** pulse `start_i` during ACCUM, during SCAN and during DONE.
  - Expect exactly one `valid_o` and unchanged timing.
  - A `start_i` one cycle after `busy_o` falls begins a new window with counters cleared, so the previous result is not carried into the new counts.
- **Reset mid-ACCUM:** assert `rst_ni`=0 for 1 cycle at E30.
  - Expect all outputs 0 and state IDLE, with no `valid_o`.
  - A subsequent `start_i` yields a correct full 64-cycle result.

Source files
------------

// File: rtl/spike_window_classifier.sv
// -----------------------------------------------------------------------------
// spike_window_classifier
//
// Readout stage for the spiking network's output layer. A start request opens a
// fixed window of WINDOW cycles during which one saturating counter per class
// counts spikes. The counts are then scanned one class per cycle to find the
// winner. Index, count and tie flag are published with a one-cycle valid pulse.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_ni       synchronous active-low reset
//   start_i      begin-window request, honoured only while idle
//   spike_i      one spike bit per class, sampled during the window
//   class_o      winning class index (lowest index wins a tie)
//   max_count_o  spike count of the winning class
//   tie_o        another class matched the winning count
//   valid_o      one-cycle pulse when the three result outputs update
//   busy_o       high whenever a window, scan or publish is in progress
// -----------------------------------------------------------------------------
module spike_window_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int WIDTH_P     = 8,
  parameter int WINDOW      = 64,
  parameter int CLASS_W     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [NUM_CLASSES-1:0] spike_i,
  output logic [CLASS_W-1:0]     class_o,
  output logic [WIDTH_P-1:0]     max_count_o,
  output logic                   tie_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  localparam int WIN_W = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CLASS_W-1:0] IDX_LAST = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [WIDTH_P-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [CLASS_W-1:0]   scan_idx_q, scan_idx_d;
  logic [WIDTH_P-1:0]   count_q [NUM_CLASSES];
  logic [WIDTH_P-1:0]   count_d [NUM_CLASSES];
  logic [CLASS_W-1:0]   best_idx_q, best_idx_d;
  logic [WIDTH_P-1:0]   best_cnt_q, best_cnt_d;
  logic                 best_tie_q, best_tie_d;
  logic [CLASS_W-1:0]   class_q, class_d;
  logic [WIDTH_P-1:0]   max_count_q, max_count_d;
  logic                 tie_q, tie_d;
  logic                 valid_q, valid_d;
  logic [WIDTH_P-1:0]   cur_cnt;

  // Count of the class currently under scan.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx_q == CLASS_W'(i)) cur_cnt = count_q[i];
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every target gets a default here first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    scan_idx_d  = scan_idx_q;
    count_d     = count_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    best_tie_d  = best_tie_q;
    class_d     = class_q;
    max_count_d = max_count_q;
    tie_d       = tie_q;
    valid_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_ACCUM;
          win_cnt_d = '0;
          for (int i = 0; i < NUM_CLASSES; i++) count_d[i] = '0;
        end
      end

      S_ACCUM: begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (spike_i[i] && (count_q[i] != CNT_MAX)) count_d[i] = count_q[i] + 1'b1;
        end
        if (win_cnt_q == WIN_LAST) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end

      S_SCAN: begin
        // Strict greater-than keeps the lower index on equal counts.
        if (scan_idx_q == '0) begin
          best_idx_d = '0;
          best_cnt_d = cur_cnt;
          best_tie_d = 1'b0;
        end else if (cur_cnt > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = cur_cnt;
          best_tie_d = 1'b0;
        end else if (cur_cnt == best_cnt_q) begin
          best_tie_d = 1'b1;
        end
        // The last class is folded in on the same edge that publishes.
        if (scan_idx_q == IDX_LAST) begin
          state_d     = S_DONE;
          class_d     = best_idx_d;
          max_count_d = best_cnt_d;
          tie_d       = best_tie_d;
          valid_d     = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      win_cnt_q   <= '0;
      scan_idx_q  <= '0;
      // NOTE: the counter bank is a handful of flops, not a RAM, so resetting
      // it is cheap and keeps an interrupted window from leaking counts.
      for (int i = 0; i < NUM_CLASSES; i++) count_q[i] <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      best_tie_q  <= 1'b0;
      class_q     <= '0;
      max_count_q <= '0;
      tie_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      scan_idx_q  <= scan_idx_d;
      count_q     <= count_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      best_tie_q  <= best_tie_d;
      class_q     <= class_d;
      max_count_q <= max_count_d;
      tie_q       <= tie_d;
      valid_q     <= valid_d;
    end
  end

  assign class_o     = class_q;
  assign max_count_o = max_count_q;
  assign tie_o       = tie_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spike_window_classifier.sv
// -----------------------------------------------------------------------------
// Testbench for spike_window_classifier. Two instances share clock and reset:
// dut_a uses the default 64-cycle window, dut_b a 300-cycle window for the
// saturation case. Expected results are queued when a window is launched and
// compared by a monitor when valid_o pulses.
// -----------------------------------------------------------------------------
module tb_spike_window_classifier;

  localparam int NC    = 10;
  localparam int WP    = 8;
  localparam int CW    = 4;
  localparam int WIN_A = 64;
  localparam int WIN_B = 300;
  localparam int LAT_A = WIN_A + NC;  // edge after E0 that publishes
  localparam int LAT_B = WIN_B + NC;

  typedef struct packed {
    logic [CW-1:0] cls;
    logic [WP-1:0] cnt;
    logic          tie;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [NC-1:0] spike_a = '0, spike_b = '0;
  logic [CW-1:0] class_a, class_b;
  logic [WP-1:0] max_a, max_b;
  logic          tie_a, tie_b, valid_a, valid_b, busy_a, busy_b;

  int   vectors = 0;
  int   miscompares = 0;
  res_t q_a[$];
  res_t q_b[$];
  res_t got_a, got_b;
  logic [NC-1:0] spike_tab [1:WIN_A];

  always #5 clk = ~clk;

  spike_window_classifier #(.NUM_CLASSES(NC), .WIDTH_P(WP), .WINDOW(WIN_A), .CLASS_W(CW)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .spike_i(spike_a),
    .class_o(class_a), .max_count_o(max_a), .tie_o(tie_a), .valid_o(valid_a), .busy_o(busy_a)
  );

  spike_window_classifier #(.NUM_CLASSES(NC), .WIDTH_P(WP), .WINDOW(WIN_B), .CLASS_W(CW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .spike_i(spike_b),
    .class_o(class_b), .max_count_o(max_b), .tie_o(tie_b), .valid_o(valid_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Scoreboard monitors: each valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_valid_unrequested", {31'd0, valid_a}, 32'd0);
      end else begin
        got_a = q_a.pop_front();
        check("a_class", {28'd0, class_a}, {28'd0, got_a.cls});
        check("a_max_count", {24'd0, max_a}, {24'd0, got_a.cnt});
        check("a_tie", {31'd0, tie_a}, {31'd0, got_a.tie});
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_valid_unrequested", {31'd0, valid_b}, 32'd0);
      end else begin
        got_b = q_b.pop_front();
        check("b_class", {28'd0, class_b}, {28'd0, got_b.cls});
        check("b_max_count", {24'd0, max_b}, {24'd0, got_b.cnt});
        check("b_tie", {31'd0, tie_b}, {31'd0, got_b.tie});
      end
    end
  end

  // Reference result for the contents of spike_tab (no saturation within 64).
  function automatic res_t model();
    int   cnt [NC];
    res_t r;
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    for (int e = 1; e <= WIN_A; e++)
      for (int k = 0; k < NC; k++) cnt[k] += int'(spike_tab[e][k]);
    r.cls = '0;
    r.cnt = WP'(cnt[0]);
    r.tie = 1'b0;
    for (int k = 1; k < NC; k++) begin
      if (cnt[k] > int'(r.cnt)) begin
        r.cls = CW'(k);
        r.cnt = WP'(cnt[k]);
        r.tie = 1'b0;
      end else if (cnt[k] == int'(r.cnt)) begin
        r.tie = 1'b1;
      end
    end
    return r;
  endfunction

  // Launches one dut_a window from the current negedge and returns at the
  // negedge after busy has fallen, so the next call starts back-to-back.
  // All spike lines are high in the start cycle, which must not be counted.
  task automatic run_a(input res_t exp, input bit stray);
    start_a = 1'b1;
    spike_a = '1;
    q_a.push_back(exp);
    for (int e = 1; e <= LAT_A + 2; e++) begin
      @(negedge clk);
      check("a_busy", {31'd0, busy_a}, {31'd0, (e - 1) <= LAT_A});
      check("a_valid_timing", {31'd0, valid_a}, {31'd0, (e - 1) == LAT_A});
      start_a = stray && (e == 10 || e == 70 || e == LAT_A + 1);
      spike_a = (e <= WIN_A) ? spike_tab[e] : NC'($urandom);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_class"}, {28'd0, class_a}, 32'd0);
    check({tag, "_max"}, {24'd0, max_a}, 32'd0);
    check({tag, "_tie"}, {31'd0, tie_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Power-on reset.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_b_busy", {31'd0, busy_b}, 32'd0);
    check("reset_b_valid", {31'd0, valid_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single winner: class 3 every cycle, class 7 on alternate cycles.
    for (int e = 1; e <= WIN_A; e++) begin
      spike_tab[e] = '0;
      spike_tab[e][3] = 1'b1;
      spike_tab[e][7] = (e % 2 == 0);
    end
    run_a('{cls: 4'd3, cnt: 8'd64, tie: 1'b0}, 1'b0);

    // Silent window.
    for (int e = 1; e <= WIN_A; e++) spike_tab[e] = '0;
    run_a('{cls: 4'd0, cnt: 8'd0, tie: 1'b1}, 1'b0);

    // Start pulses in ACCUM, SCAN and DONE are ignored.
    for (int e = 1; e <= WIN_A; e++) begin
      spike_tab[e] = '0;
      spike_tab[e][3] = 1'b1;
      spike_tab[e][7] = (e % 2 == 0);
    end
    run_a('{cls: 4'd3, cnt: 8'd64, tie: 1'b0}, 1'b1);

    // Back-to-back: counters restart from zero, class 3 no longer wins.
    for (int e = 1; e <= WIN_A; e++) begin
      spike_tab[e] = '0;
      spike_tab[e][6] = (e <= 20);
      spike_tab[e][4] = (e <= 10);
    end
    run_a('{cls: 4'd6, cnt: 8'd20, tie: 1'b0}, 1'b0);

    // Tie between classes 2 and 8; lower index wins.
    for (int e = 1; e <= WIN_A; e++) begin
      spike_tab[e] = '0;
      spike_tab[e][2] = 1'b1;
      spike_tab[e][8] = 1'b1;
    end
    run_a('{cls: 4'd2, cnt: 8'd64, tie: 1'b1}, 1'b0);

    // Reset at E30 of a window: no result, everything cleared.
    for (int e = 1; e <= WIN_A; e++) spike_tab[e] = NC'($urandom);
    start_a = 1'b1;
    spike_a = '0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      start_a = 1'b0;
      spike_a = spike_tab[e];
      if (e == 30) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs_zero("midreset");
    for (int c = 0; c < LAT_A + 10; c++) begin
      @(negedge clk);
      check("midreset_no_valid", {31'd0, valid_a}, 32'd0);
    end
    check("midreset_idle", {31'd0, busy_a}, 32'd0);

    // Full window after the interrupted one.
    for (int e = 1; e <= WIN_A; e++) begin
      spike_tab[e] = '0;
      spike_tab[e][9] = (e <= 50);
      spike_tab[e][1] = (e % 3 == 0);
    end
    run_a('{cls: 4'd9, cnt: 8'd50, tie: 1'b0}, 1'b0);

    // Random windows against the reference model.
    for (int r = 0; r < 3; r++) begin
      for (int e = 1; e <= WIN_A; e++) spike_tab[e] = NC'($urandom) & NC'($urandom);
      run_a(model(), 1'b0);
    end

    // Saturation on the 300-cycle instance.
    start_b = 1'b1;
    spike_b = '1;
    q_b.push_back('{cls: 4'd5, cnt: 8'd255, tie: 1'b0});
    for (int e = 1; e <= LAT_B + 2; e++) begin
      @(negedge clk);
      check("b_busy", {31'd0, busy_b}, {31'd0, (e - 1) <= LAT_B});
      check("b_valid_timing", {31'd0, valid_b}, {31'd0, (e - 1) == LAT_B});
      start_b = 1'b0;
      if (e <= WIN_B) begin
        spike_b = '0;
        spike_b[5] = 1'b1;
        spike_b[1] = (e <= 200);
      end else begin
        spike_b = NC'($urandom);
      end
    end

    repeat (2) @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
